// File: rtl/lfsr_chk_pkg.sv
// lfsr_chk_pkg
//   Shared definitions for the LfsrFib generator / lfsr_fib_checker pair.
//   - chkState_t : checker FSM state encoding (SEARCH, VERIFY, LOCKED)
//   - DEF_LN     : default LFSR length in bits
//   - DEF_TAPS   : default tap mask; bit i set means state bit i feeds the XOR
//   - lfsr_parity: XOR-reduction of (state & taps), i.e. the next Fibonacci bit
//   Bit 0 of an LFSR state is the most recently shifted-in bit.
package lfsr_chk_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chkState_t;

  localparam int         DEF_LN   = 8;
  localparam logic [7:0] DEF_TAPS = 8'h2D;

  // Operands are zero-extended to 64 bits by the caller, so any LN up to 64
  // shares this one function.
  function automatic logic lfsr_parity(input logic [63:0] state,
                                       input logic [63:0] taps);
    return ^(state & taps);
  endfunction

endpackage

// File: rtl/lfsr_fib_checker.sv
// lfsr_fib_checker
//   Receive-side partner of the LfsrFib pattern generator. Accepts one serial
//   bit per checkBit call, self-synchronises a local Fibonacci LFSR to the
//   stream, then flywheels and counts mismatches.
//
//   Handshake: both methods are always ready (RDY tied to 1). A bit is
//   consumed on every rising CLK edge where checkBit__ENA = 1; with ENA low
//   every register holds. clearCounts__ENA acts on its own, independent of
//   checkBit__ENA.
//
// Ports
//   CLK               clock
//   RST               synchronous active-high reset (overrides any ENA)
//   checkBit__ENA     bit-valid strobe
//   checkBit_v        received bit
//   checkBit__RDY     always 1
//   clearCounts__ENA  zero the statistics counters next cycle
//   clearCounts__RDY  always 1
//   locked            registered lock flag
//   errCount          saturating mismatch count, accumulates in LOCKED only
//   bitCount          (LFSR_CHK_BITCNT_EN only) saturating count of bits
//                     accepted in LOCKED
//   dbgState          current FSM state, for observation only
//
// Configuration macro: LFSR_CHK_BITCNT_EN adds the bitCount output/counter.
module lfsr_fib_checker
  import lfsr_chk_pkg::*;
#(
  parameter int             LN          = DEF_LN,
  parameter logic [LN-1:0]  TAPS        = LN'(DEF_TAPS),
  parameter int             LOCK_CNT    = 16,
  parameter int             UNLOCK_ERRS = 4,
  parameter int             CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             checkBit__ENA,
  input  logic             checkBit_v,
  output logic             checkBit__RDY,
  input  logic             clearCounts__ENA,
  output logic             clearCounts__RDY,
  output logic             locked,
  output logic [CNT_W-1:0] errCount,
`ifdef LFSR_CHK_BITCNT_EN
  output logic [CNT_W-1:0] bitCount,
`endif
  output chkState_t        dbgState
);

  localparam int LW = (LN > 2) ? $clog2(LN) : 1;
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int EW = $clog2(UNLOCK_ERRS + 1);

  // Pre-increment values at which each counter completes its run.
  localparam logic [LW-1:0] LOAD_LAST   = LW'(LN - 1);
  localparam logic [MW-1:0] LOCK_LAST   = MW'(LOCK_CNT - 1);
  localparam logic [EW-1:0] UNLOCK_LAST = EW'(UNLOCK_ERRS - 1);

  chkState_t        state,    stateNext;
  logic [LN-1:0]    lfsr,     lfsrNext;
  logic [LW-1:0]    loadCnt,  loadCntNext;
  logic [MW-1:0]    matchCnt, matchCntNext;
  logic [EW-1:0]    errRun,   errRunNext;
  logic             lockedNext;
  logic [CNT_W-1:0] errCountNext;
  logic             pred;
  logic             errHit;
  logic [LN-1:0]    shiftedIn;

  assign checkBit__RDY    = 1'b1;
  assign clearCounts__RDY = 1'b1;
  assign dbgState         = state;

  assign pred      = lfsr_parity(64'(lfsr), 64'(TAPS));
  assign shiftedIn = {lfsr[LN-2:0], checkBit_v};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= SEARCH;
      lfsr     <= '0;
      loadCnt  <= '0;
      matchCnt <= '0;
      errRun   <= '0;
      locked   <= 1'b0;
      errCount <= '0;
    end else begin
      state    <= stateNext;
      lfsr     <= lfsrNext;
      loadCnt  <= loadCntNext;
      matchCnt <= matchCntNext;
      errRun   <= errRunNext;
      locked   <= lockedNext;
      errCount <= errCountNext;
    end
  end

  always_comb begin
    stateNext    = state;
    lfsrNext     = lfsr;
    loadCntNext  = loadCnt;
    matchCntNext = matchCnt;
    errRunNext   = errRun;
    lockedNext   = locked;
    errHit       = 1'b0;

    if (checkBit__ENA) begin
      unique case (state)
        SEARCH: begin
          lfsrNext    = shiftedIn;
          loadCntNext = loadCnt + 1'b1;
          if (loadCnt == LOAD_LAST) begin
            // A full register is loaded. All-zero is the LFSR's dead state
            // and would predict zeros forever, so it is not a lock candidate.
            loadCntNext = '0;
            if (shiftedIn != '0) begin
              stateNext    = VERIFY;
              matchCntNext = '0;
            end
          end
        end

        VERIFY: begin
          lfsrNext = shiftedIn;
          if (checkBit_v == pred) begin
            if (matchCnt == LOCK_LAST) begin
              stateNext    = LOCKED;
              lockedNext   = 1'b1;
              errRunNext   = '0;
              matchCntNext = '0;
            end else begin
              matchCntNext = matchCnt + 1'b1;
            end
          end else begin
            // The offending bit is already in lfsr, so it is the first of
            // the next load.
            stateNext    = SEARCH;
            loadCntNext  = LW'(1);
            matchCntNext = '0;
          end
        end

        LOCKED: begin
          // Flywheel: the register follows its own prediction so that line
          // errors cannot corrupt it.
          lfsrNext = {lfsr[LN-2:0], pred};
          if (checkBit_v != pred) begin
            errHit       = 1'b1;
            matchCntNext = '0;
            if (errRun == UNLOCK_LAST) begin
              stateNext   = SEARCH;
              loadCntNext = '0;
              lockedNext  = 1'b0;
              errRunNext  = '0;
            end else begin
              errRunNext = errRun + 1'b1;
            end
          end else if (matchCnt == LOCK_LAST) begin
            // A clean run forgives earlier scattered errors.
            errRunNext   = '0;
            matchCntNext = '0;
          end else begin
            matchCntNext = matchCnt + 1'b1;
          end
        end

        default: begin
          stateNext  = SEARCH;
          lockedNext = 1'b0;
        end
      endcase
    end
  end

  // Clear takes priority over a same-cycle increment.
  always_comb begin
    errCountNext = errCount;
    if (clearCounts__ENA) begin
      errCountNext = '0;
    end else if (errHit && (errCount != '1)) begin
      errCountNext = errCount + 1'b1;
    end
  end

`ifdef LFSR_CHK_BITCNT_EN
  logic [CNT_W-1:0] bitCountNext;

  always_comb begin
    bitCountNext = bitCount;
    if (clearCounts__ENA) begin
      bitCountNext = '0;
    end else if (checkBit__ENA && (state == LOCKED) && (bitCount != '1)) begin
      bitCountNext = bitCount + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      bitCount <= '0;
    end else begin
      bitCount <= bitCountNext;
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_fib_checker.sv
// tb_lfsr_fib_checker
//   Self-checking bench for lfsr_fib_checker. A bit-history generator model
//   produces the LfsrFib stream; a behavioural checker model (bit window in a
//   queue, integer counters) supplies every expected value.
//   Builds with or without LFSR_CHK_BITCNT_EN.
module tb_lfsr_fib_checker;
  import lfsr_chk_pkg::*;

  localparam int         LN          = 8;
  localparam logic [7:0] TAPS        = 8'h2D;
  localparam int         LOCK_CNT    = 16;
  localparam int         UNLOCK_ERRS = 4;
  localparam int         CNT_W       = 4;   // small so saturation is reachable
  localparam int         CNT_MAX     = (1 << CNT_W) - 1;

  // ---------------- clock / reset / DUT ----------------
  logic             CLK = 1'b0;
  logic             rstIn = 1'b1;
  logic             enaIn = 1'b0;
  logic             vIn = 1'b0;
  logic             clrIn = 1'b0;
  logic             rdyBit, rdyClr, locked;
  logic [CNT_W-1:0] errCount;
  chkState_t        dbgState;
`ifdef LFSR_CHK_BITCNT_EN
  logic [CNT_W-1:0] bitCount;
`endif

  always #5 CLK = ~CLK;

  lfsr_fib_checker #(
    .LN(LN), .TAPS(TAPS), .LOCK_CNT(LOCK_CNT),
    .UNLOCK_ERRS(UNLOCK_ERRS), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK),
    .RST(rstIn),
    .checkBit__ENA(enaIn),
    .checkBit_v(vIn),
    .checkBit__RDY(rdyBit),
    .clearCounts__ENA(clrIn),
    .clearCounts__RDY(rdyClr),
    .locked(locked),
    .errCount(errCount),
`ifdef LFSR_CHK_BITCNT_EN
    .bitCount(bitCount),
`endif
    .dbgState(dbgState)
  );

  int nChecks = 0;
  int nPass   = 0;

  // ---------------- generator model ----------------
  // genHist holds the last LN emitted bits, oldest first. Each new bit is the
  // XOR of the bits emitted (i+1) steps ago for every set tap i.
  bit genHist[$];

  task automatic gen_seed(input logic [7:0] seed);
    genHist.delete();
    for (int i = LN - 1; i >= 0; i--) genHist.push_back(seed[i]);
  endtask

  function automatic bit gen_next();
    bit b = 1'b0;
    for (int i = 0; i < LN; i++) if (TAPS[i]) b ^= genHist[LN - 1 - i];
    genHist.push_back(b);
    void'(genHist.pop_front());
    return b;
  endfunction

  // ---------------- checker reference model ----------------
  chkState_t mState;
  bit        win[$];   // checker's view of the last LN bits, newest at back
  int        mLoads, mMatches, mErrRun, mErr, mBits;
  logic      mLocked;

  task automatic model_reset();
    mState = SEARCH;
    win.delete();
    for (int i = 0; i < LN; i++) win.push_back(1'b0);
    mLoads = 0; mMatches = 0; mErrRun = 0; mErr = 0; mBits = 0;
    mLocked = 1'b0;
  endtask

  function automatic bit model_pred();
    bit p = 1'b0;
    for (int i = 0; i < LN; i++) if (TAPS[i]) p ^= win[LN - 1 - i];
    return p;
  endfunction

  task automatic win_push(input bit b);
    win.push_back(b);
    void'(win.pop_front());
  endtask

  task automatic model_step(input bit v, input bit ena, input bit clr);
    bit p, errHit, bitHit, allZero;
    errHit = 1'b0;
    bitHit = 1'b0;
    if (ena) begin
      p = model_pred();
      case (mState)
        SEARCH: begin
          win_push(v);
          mLoads++;
          if (mLoads == LN) begin
            allZero = 1'b1;
            foreach (win[i]) if (win[i]) allZero = 1'b0;
            mLoads = 0;
            if (!allZero) begin mState = VERIFY; mMatches = 0; end
          end
        end
        VERIFY: begin
          win_push(v);
          if (v == p) begin
            mMatches++;
            if (mMatches == LOCK_CNT) begin
              mState = LOCKED; mLocked = 1'b1; mErrRun = 0; mMatches = 0;
            end
          end else begin
            mState = SEARCH; mLoads = 1; mMatches = 0;
          end
        end
        default: begin
          bitHit = 1'b1;
          win_push(p);
          if (v != p) begin
            errHit = 1'b1;
            mMatches = 0;
            mErrRun++;
            if (mErrRun == UNLOCK_ERRS) begin
              mState = SEARCH; mLoads = 0; mLocked = 1'b0; mErrRun = 0;
            end
          end else begin
            mMatches++;
            if (mMatches == LOCK_CNT) begin mErrRun = 0; mMatches = 0; end
          end
        end
      endcase
    end
    if (clr) begin
      mErr = 0; mBits = 0;
    end else begin
      if (errHit && mErr < CNT_MAX) mErr++;
      if (bitHit && mBits < CNT_MAX) mBits++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_bit(input bit v, input bit ena, input bit clr);
    @(negedge CLK);
    vIn = v; enaIn = ena; clrIn = clr;
    @(posedge CLK);
    #1;
    model_step(v, ena, clr);
    vIn = 1'b0; enaIn = 1'b0; clrIn = 1'b0;
  endtask

  task automatic apply_reset(input bit withEna);
    @(negedge CLK);
    rstIn = 1'b1; enaIn = withEna; vIn = 1'b1;
    @(posedge CLK);
    #1;
    rstIn = 1'b0; enaIn = 1'b0; vIn = 1'b0;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset(1'b0);
    apply_reset(1'b1);
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      nChecks++;
      if (locked !== 1'b0) $display("FAIL reset_idle_locked cyc %0d: got %b want 0", i, locked);
      else nPass++;
      nChecks++;
      if (errCount !== '0) $display("FAIL reset_idle_err cyc %0d: got %0d want 0", i, errCount);
      else nPass++;
      nChecks++;
      if (rdyBit !== 1'b1 || rdyClr !== 1'b1)
        $display("FAIL reset_idle_rdy cyc %0d: got %b%b want 11", i, rdyBit, rdyClr);
      else nPass++;
      nChecks++;
      if (dbgState !== SEARCH) $display("FAIL reset_idle_state cyc %0d: got %0d want %0d", i, dbgState, SEARCH);
      else nPass++;
    end
  endtask

  // 24 clean bits: LN loads plus LOCK_CNT verified matches.
  task automatic test_lock_acquire(input string tag, input int errWant);
    for (int i = 1; i <= LN + LOCK_CNT; i++) begin
      send_bit(gen_next(), 1'b1, 1'b0);
      nChecks++;
      if (locked !== (i == LN + LOCK_CNT))
        $display("FAIL %s_locked bit %0d: got %b want %b", tag, i, locked, (i == LN + LOCK_CNT));
      else nPass++;
      nChecks++;
      if (errCount !== CNT_W'(errWant))
        $display("FAIL %s_err bit %0d: got %0d want %0d", tag, i, errCount, errWant);
      else nPass++;
      nChecks++;
      if (dbgState !== mState) $display("FAIL %s_state bit %0d: got %0d want %0d", tag, i, dbgState, mState);
      else nPass++;
    end
  endtask

  task automatic test_single_flip();
    send_bit(gen_next() ^ 1'b1, 1'b1, 1'b0);
    nChecks++;
    if (errCount !== CNT_W'(1) || locked !== 1'b1)
      $display("FAIL single_flip: got err=%0d locked=%b want err=1 locked=1", errCount, locked);
    else nPass++;
    for (int i = 0; i < 20; i++) begin
      send_bit(gen_next(), 1'b1, 1'b0);
      nChecks++;
      if (errCount !== CNT_W'(1) || locked !== 1'b1)
        $display("FAIL flywheel bit %0d: got err=%0d locked=%b want err=1 locked=1", i, errCount, locked);
      else nPass++;
    end
  endtask

  // Four flips at positions 0,3,6,9; optional clear coincides with the first.
  task automatic test_unlock(input bit clrOnFirst);
    int want;
    send_bit(1'b0, 1'b0, 1'b1);
    nChecks++;
    if (errCount !== '0) $display("FAIL clear_idle: got %0d want 0", errCount);
    else nPass++;
    for (int i = 0; i < 10; i++) begin
      bit flip = (i % 3 == 0);
      send_bit(gen_next() ^ flip, 1'b1, clrOnFirst && i == 0);
      nChecks++;
      if (locked !== (i < 9)) $display("FAIL unlock_locked pos %0d: got %b want %b", i, locked, (i < 9));
      else nPass++;
      nChecks++;
      if (errCount !== CNT_W'(mErr)) $display("FAIL unlock_err pos %0d: got %0d want %0d", i, errCount, mErr);
      else nPass++;
    end
    want = clrOnFirst ? 3 : 4;
    nChecks++;
    if (errCount !== CNT_W'(want)) $display("FAIL unlock_total: got %0d want %0d", errCount, want);
    else nPass++;
    test_lock_acquire(clrOnFirst ? "relock_b" : "relock_a", want);
  endtask

  task automatic test_reset_locked();
    send_bit(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) send_bit(gen_next() ^ (i % 3 == 0), 1'b1, 1'b0);
    nChecks++;
    if (errCount !== CNT_W'(3) || locked !== 1'b1)
      $display("FAIL pre_reset: got err=%0d locked=%b want err=3 locked=1", errCount, locked);
    else nPass++;
    apply_reset(1'b1);
    nChecks++;
    if (locked !== 1'b0 || errCount !== '0 || dbgState !== SEARCH)
      $display("FAIL reset_locked: got locked=%b err=%0d state=%0d want 0 0 %0d",
               locked, errCount, dbgState, SEARCH);
    else nPass++;
`ifdef LFSR_CHK_BITCNT_EN
    nChecks++;
    if (bitCount !== '0) $display("FAIL reset_bitcount: got %0d want 0", bitCount);
    else nPass++;
`endif
  endtask

  task automatic test_zeros();
    for (int i = 0; i < 64; i++) begin
      send_bit(1'b0, 1'b1, 1'b0);
      nChecks++;
      if (dbgState !== SEARCH || locked !== 1'b0)
        $display("FAIL zeros bit %0d: got state=%0d locked=%b want %0d 0", i, dbgState, locked, SEARCH);
      else nPass++;
    end
  endtask

  task automatic test_saturate();
    test_lock_acquire("sat_lock", 0);
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 3; k++) send_bit(gen_next() ^ 1'b1, 1'b1, 1'b0);
      for (int k = 0; k < LOCK_CNT; k++) send_bit(gen_next(), 1'b1, 1'b0);
      nChecks++;
      if (errCount !== CNT_W'(mErr) || locked !== 1'b1)
        $display("FAIL saturate round %0d: got err=%0d locked=%b want err=%0d locked=1",
                 r, errCount, locked, mErr);
      else nPass++;
    end
    nChecks++;
    if (errCount !== CNT_W'(CNT_MAX)) $display("FAIL saturate_final: got %0d want %0d", errCount, CNT_MAX);
    else nPass++;
  endtask

`ifdef LFSR_CHK_BITCNT_EN
  task automatic test_bitcount();
    for (int i = 0; i < 5; i++) send_bit(gen_next(), 1'b1, 1'b0);
    nChecks++;
    if (bitCount !== CNT_W'(mBits)) $display("FAIL bitcount_run: got %0d want %0d", bitCount, mBits);
    else nPass++;
    send_bit(gen_next(), 1'b1, 1'b1);
    nChecks++;
    if (bitCount !== '0) $display("FAIL bitcount_clear: got %0d want 0", bitCount);
    else nPass++;
  endtask
`endif

  task automatic test_random();
    int rates[3] = '{0, 20, 3};
    apply_reset(1'b0);
    gen_seed(8'($urandom_range(1, 255)));
    for (int s = 0; s < 9; s++) begin
      int rate = rates[s % 3];
      for (int i = 0; i < 80; i++) begin
        bit ena  = ($urandom_range(0, 3) != 0);
        bit clr  = ($urandom_range(0, 29) == 0);
        bit flip = (rate != 0) && ($urandom_range(1, rate) == 1);
        bit v    = ena ? (gen_next() ^ flip) : 1'($urandom_range(0, 1));
        send_bit(v, ena, clr);
        nChecks++;
        if (locked !== mLocked || errCount !== CNT_W'(mErr) || dbgState !== mState)
          $display("FAIL random seg %0d cyc %0d: got locked=%b err=%0d state=%0d want %b %0d %0d",
                   s, i, locked, errCount, dbgState, mLocked, mErr, mState);
        else nPass++;
`ifdef LFSR_CHK_BITCNT_EN
        nChecks++;
        if (bitCount !== CNT_W'(mBits))
          $display("FAIL random_bitcount seg %0d cyc %0d: got %0d want %0d", s, i, bitCount, mBits);
        else nPass++;
`endif
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    model_reset();
    gen_seed(8'h01);
    test_reset();
    test_lock_acquire("lock", 0);
    test_single_flip();
    test_unlock(1'b0);
    test_unlock(1'b1);
    test_reset_locked();
    test_zeros();
    test_saturate();
`ifdef LFSR_CHK_BITCNT_EN
    test_bitcount();
`endif
    test_random();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
